// File: rtl/actuator_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : actuator_scheduler
// Description : Round-robin scheduler granting one of four actuators at a
//               time. Each grant is held for DWELL_CYCLES cycles, followed by
//               GUARD_CYCLES dead cycles before the next arbitration.
// Revision    : 1.0 - initial release
// ============================================================================
module actuator_scheduler #(
    parameter int unsigned DWELL_CYCLES = 8,
    parameter int unsigned GUARD_CYCLES = 2
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       enable,
    input  logic [3:0] req,
    output logic [1:0] sel,
    output logic       active,
    output logic [3:0] grant,
    output logic [3:0] done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GUARD = 2'd2
    } state_e;

    // Terminal counts; the shared counter restarts at zero on every state entry.
    localparam logic [7:0] DWELL_LAST = 8'(DWELL_CYCLES - 1);
    localparam logic [7:0] GUARD_LAST = 8'(GUARD_CYCLES - 1);

    state_e     state_q, state_d;
    logic [1:0] sel_q,   sel_d;
    logic [1:0] last_q,  last_d;
    logic [7:0] cnt_q,   cnt_d;
    logic       active_q, active_d;
    logic [3:0] grant_q,  grant_d;
    logic [3:0] done_q,   done_d;
    // Low for the first edge after reset release so no grant can be issued
    // on that edge.
    logic       armed_q;

    logic [1:0] pick_idx;
    logic       pick_valid;

    // Round-robin search: last+1, last+2, last+3, then last itself.
    always_comb begin
        logic [1:0] cand;
        pick_idx   = last_q;
        pick_valid = 1'b0;
        cand       = last_q;
        for (int k = 4; k >= 1; k--) begin
            cand = last_q + 2'(k);
            if (req[cand]) begin
                pick_idx   = cand;
                pick_valid = 1'b1;
            end
        end
    end

    // Next-state and registered-output decode.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        done_d  = 4'b0000;
        case (state_q)
            ST_IDLE: begin
                if (enable && armed_q && pick_valid) begin
                    state_d = ST_GRANT;
                    sel_d   = pick_idx;
                    last_d  = pick_idx;
                    cnt_d   = 8'd0;
                end
            end
            ST_GRANT: begin
                if (!enable || !req[sel_q]) begin
                    // Abort: requester withdrew or arbitration disabled.
                    state_d = ST_GUARD;
                    cnt_d   = 8'd0;
                end else if (cnt_q == DWELL_LAST) begin
                    state_d = ST_GUARD;
                    cnt_d   = 8'd0;
                    done_d  = 4'b0001 << sel_q;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_GUARD: begin
                if (cnt_q == GUARD_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 8'd0;
            end
        endcase
        active_d = (state_d == ST_GRANT);
        grant_d  = active_d ? (4'b0001 << sel_d) : 4'b0000;
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            sel_q    <= 2'b11;
            last_q   <= 2'b11;
            cnt_q    <= 8'd0;
            active_q <= 1'b0;
            grant_q  <= 4'b0000;
            done_q   <= 4'b0000;
            armed_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
            grant_q  <= grant_d;
            done_q   <= done_d;
            armed_q  <= 1'b1;
        end
    end

    assign sel    = sel_q;
    assign active = active_q;
    assign grant  = grant_q;
    assign done   = done_q;

endmodule
`default_nettype wire
